// File: rtl/exmem_arb_pkg.sv
// Shared types and constants for the exmem port-2 arbiter: FSM states,
// requester IDs and the lock-counter width helper.
package exmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      LOCK  = 2'd2
   } arb_state_t;

   localparam logic REQ_DISP = 1'b0;
   localparam logic REQ_GAME = 1'b1;

   localparam int DEFAULT_MAX_LOCK = 16;

   // The counter must be able to hold MAX_LOCK itself, hence the +1.
   function automatic int lock_cnt_width(input int max_lock);
      return $clog2(max_lock + 1);
   endfunction

   localparam int LOCK_CNT_W = lock_cnt_width(DEFAULT_MAX_LOCK);

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker. The requester granted last
// loses a tie; the display requester is masked while a lock is held.
module arb_rr2
   import exmem_arb_pkg::*;
(
   input  logic [1:0] eligible,
   input  logic       last_gnt,
   input  logic       lock_active,
   output logic [1:0] winner
);

   logic [1:0] cand;

   always_comb begin
      cand = eligible;
      winner = 2'b00;
      if (lock_active) cand[REQ_DISP] = 1'b0;
      if (cand == 2'b11) winner = (last_gnt == REQ_GAME) ? 2'b01 : 2'b10;
      else winner = cand;
   end

endmodule

// File: rtl/exmem_port2_arbiter.sv
// Arbiter for exmem port 2: display reads (r0) versus game-logic accesses
// with an optional bounded lock (r1). All memory-side outputs are registered.
module exmem_port2_arbiter
   import exmem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_LOCK   = 16
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  r0_req,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   output logic                  r0_gnt,
   output logic                  r0_rvalid,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   input  logic                  r1_lock,
   output logic                  r1_gnt,
   output logic                  r1_rvalid,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  lock_err
);

   localparam int CW = lock_cnt_width(MAX_LOCK);
   localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK);

   arb_state_t    state, state_next;
   logic          last_gnt, last_gnt_next;
   logic [CW-1:0] lock_cnt, lock_cnt_next, cnt_inc;
   logic          lock_err_next;
   logic          in_lock, timeout, lock_hold;
   logic [1:0]    eligible, winner;

   assign in_lock  = (state == LOCK);
   assign cnt_inc  = lock_cnt + 1'b1;
   assign timeout  = in_lock && (cnt_inc == LOCK_LIMIT);
   // The lock keeps r0 out only while it is still held on this edge.
   assign lock_hold = in_lock && r1_lock && !timeout;
   // A requester whose grant pulse is high right now has been served.
   assign eligible = {r1_req && !r1_gnt, r0_req && !r0_gnt};

   assign r0_rdata = mem_rdata;
   assign r1_rdata = mem_rdata;

   arb_rr2 u_pick (
      .eligible    (eligible),
      .last_gnt    (last_gnt),
      .lock_active (lock_hold),
      .winner      (winner)
   );

   always_comb begin
      state_next    = state;
      last_gnt_next = last_gnt;
      lock_cnt_next = lock_cnt;
      lock_err_next = lock_err;
      if (in_lock) lock_cnt_next = cnt_inc;
      if (timeout) begin
         lock_err_next = 1'b1;
         last_gnt_next = REQ_GAME;
      end
      if (winner[REQ_DISP]) last_gnt_next = REQ_DISP;
      if (winner[REQ_GAME]) last_gnt_next = REQ_GAME;
      if (lock_hold) begin
         state_next = LOCK;
      end else if (winner[REQ_GAME] && r1_lock) begin
         state_next    = LOCK;
         lock_cnt_next = '0;
      end else if (winner != 2'b00) begin
         state_next = GRANT;
      end else begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         last_gnt  <= REQ_GAME;
         lock_cnt  <= '0;
         lock_err  <= 1'b0;
         r0_gnt    <= 1'b0;
         r1_gnt    <= 1'b0;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         state     <= state_next;
         last_gnt  <= last_gnt_next;
         lock_cnt  <= lock_cnt_next;
         lock_err  <= lock_err_next;
         r0_gnt    <= winner[REQ_DISP];
         r1_gnt    <= winner[REQ_GAME];
         r0_rvalid <= r0_gnt;
         r1_rvalid <= r1_gnt && !mem_we;
         mem_we    <= 1'b0;
         if (winner[REQ_DISP]) begin
            mem_addr <= r0_addr;
         end else if (winner[REQ_GAME]) begin
            mem_addr  <= r1_addr;
            mem_wdata <= r1_wdata;
            mem_we    <= r1_we;
         end
      end
   end

endmodule
